// File: rtl/capt_pkg.sv
// Shared definitions for the capture counter and its drain companion.
package capt_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_ONE   = 2'b01,
    OP_ALL   = 2'b10,
    OP_FLUSH = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRAIN = 2'b01,
    ST_GAP   = 2'b10
  } state_e;

  localparam int DEPTH_DEFAULT = 6;

endpackage

// File: rtl/capt_drain_gap_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module gap_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (rst)                 cnt <= '0;
    else if (load)           cnt <= load_val;
    else if (en && cnt != 0) cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/capt_drain.sv
// Token drain: arms DEPTH tokens on load, releases them over valid/ready.
// Optional stall watchdog enabled by defining CAPT_DRAIN_WATCHDOG_EN.
module capt_drain
  import capt_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int CW      = 3,
  parameter int GAP     = 1,
  parameter int TIMEOUT = 15
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          load,
  input  logic [1:0]    op,
  input  logic          rel_ready,
  output logic          rel_valid,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          busy,
  output logic          ovr,
  output logic          timeout
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LD = (GAP > 0) ? GW'(GAP - 1) : '0;

  state_e        state, state_n;
  logic [CW-1:0] count_n;
  logic          mode_all, mode_n;
  logic          rv_n, ovr_n;
  logic          hs, gap_ld, gap_done, wd_fire;

  assign hs = rel_valid && rel_ready;

  gap_timer #(.W(GW)) u_gap (
    .clock    (clock),
    .rst      (rst),
    .load     (gap_ld),
    .load_val (GAP_LD),
    .en       (state == ST_GAP),
    .done     (gap_done)
  );

`ifdef CAPT_DRAIN_WATCHDOG_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic wd_stall, wd_done;

  // Reloaded whenever the drain is not stalled, so only consecutive stall cycles count.
  assign wd_stall = (state == ST_DRAIN) && !rel_ready;

  gap_timer #(.W(TW)) u_wd (
    .clock    (clock),
    .rst      (rst),
    .load     (!wd_stall),
    .load_val (TW'(TIMEOUT - 1)),
    .en       (wd_stall),
    .done     (wd_done)
  );

  assign wd_fire = wd_stall && wd_done;

  always_ff @(posedge clock) begin
    if (rst) timeout <= 1'b0;
    else     timeout <= wd_fire && (op != OP_FLUSH);
  end
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    count_n = count;
    mode_n  = mode_all;
    rv_n    = rel_valid;
    ovr_n   = load && (state != ST_IDLE);
    gap_ld  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          count_n = CW'(DEPTH);
        end else if (op == OP_FLUSH) begin
          count_n = '0;
        end else if ((op == OP_ONE || op == OP_ALL) && count != '0) begin
          state_n = ST_DRAIN;
          mode_n  = (op == OP_ALL);
          rv_n    = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Flush beats a same-cycle handshake; that release counts as taken.
        if (op == OP_FLUSH) begin
          state_n = ST_IDLE;
          count_n = '0;
          rv_n    = 1'b0;
        end else if (hs) begin
          count_n = count - 1'b1;
          if (!mode_all || count == CW'(1)) begin
            state_n = ST_IDLE;
            rv_n    = 1'b0;
          end else if (GAP > 0) begin
            state_n = ST_GAP;
            rv_n    = 1'b0;
            gap_ld  = 1'b1;
          end
        end else if (wd_fire) begin
          state_n = ST_IDLE;
          rv_n    = 1'b0;
        end
      end
      ST_GAP: begin
        if (op == OP_FLUSH) begin
          state_n = ST_IDLE;
          count_n = '0;
        end else if (gap_done) begin
          state_n = ST_DRAIN;
          rv_n    = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        rv_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      mode_all  <= 1'b0;
      rel_valid <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      mode_all  <= mode_n;
      rel_valid <= rv_n;
      ovr       <= ovr_n;
    end
  end

  assign empty = (count == '0);
  assign busy  = (state != ST_IDLE);

endmodule
